// File: rtl/packet_receiver.sv
// packet_receiver: checks framed link bytes and publishes the payload into a double-buffered 64-byte packet memory.
// Latency: new/error pulses one cycle after the deciding byte's edge; read data one cycle after the index is sampled.
// Backpressure: none; one byte is consumed on every rx_valid cycle, and the block never stalls the link.
//
// Ports:
//   clock, reset_n               : rising-edge clock, synchronous active-low reset
//   rx_data, rx_valid            : incoming link byte stream (SYNC, LEN, payload, CHK)
//   incoming_packet_read_index   : byte address into the published packet
//   incoming_packet_read_data    : registered read data (00 beyond the published length)
//   incoming_packet_new          : one-cycle pulse when a packet is published
//   incoming_packet_length       : payload length of the published packet (0..64)
//   frame_error                  : one-cycle pulse when a frame is dropped
//   busy                         : high while a frame is in progress
module packet_receiver #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_WIDTH  = 11
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [5:0] incoming_packet_read_index,
    output logic [7:0] incoming_packet_read_data,
    output logic       incoming_packet_new,
    output logic [6:0] incoming_packet_length,
    output logic       frame_error,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LEN     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CHECK   = 2'd3
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE  = TIMEOUT_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [6:0]               len_q, len_d;          // LEN of the frame in progress
    logic [5:0]               cnt_q, cnt_d;          // payload bytes received so far
    logic [7:0]               chk_q, chk_d;          // running XOR of LEN and payload
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;          // idle clocks since the last byte
    logic                     bank_q, bank_d;        // read bank; write bank is its inverse
    logic [6:0]               pkt_len_q, pkt_len_d;  // published length
    logic                     new_q, new_d;
    logic                     err_q, err_d;
    logic                     busy_q;
    logic [7:0]               rd_q;

    // Two 64-byte banks addressed as {bank, index}; deliberately not reset.
    logic [7:0] mem [0:127];
    logic       mem_we;

    logic       len_ok;
    logic       last_byte;
    logic       tmo_expire;
    logic       rd_in_range;

    assign len_ok      = (rx_data != 8'd0) && (rx_data <= 8'd64);
    assign last_byte   = ({1'b0, cnt_q} == (len_q - 7'd1));
    assign tmo_expire  = (tmo_q == TMO_LAST);
    assign rd_in_range = ({1'b0, incoming_packet_read_index} < pkt_len_q);

    // Next-state and decision logic.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        chk_d     = chk_q;
        bank_d    = bank_q;
        pkt_len_d = pkt_len_q;
        tmo_d     = '0;
        new_d     = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Anything other than the sync marker is line noise.
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (len_ok) begin
                        len_d   = rx_data[6:0];
                        chk_d   = rx_data;
                        cnt_d   = '0;
                        state_d = S_PAYLOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    mem_we = 1'b1;
                    chk_d  = chk_q ^ rx_data;
                    cnt_d  = cnt_q + 6'd1;
                    if (last_byte) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (rx_valid) begin
                    state_d = S_IDLE;
                    if (rx_data == chk_q) begin
                        // Publish: the freshly written bank becomes readable.
                        new_d     = 1'b1;
                        bank_d    = ~bank_q;
                        pkt_len_d = len_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Inter-byte timeout inside a frame. A byte on the expiry cycle
        // takes priority: the counter simply clears via the default above.
        if ((state_q != S_IDLE) && !rx_valid) begin
            if (tmo_expire) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_ONE;
            end
        end
    end

    // FSM and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            chk_q     <= '0;
            tmo_q     <= '0;
            bank_q    <= 1'b0;
            pkt_len_q <= '0;
            new_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            rd_q      <= 8'h00;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            chk_q     <= chk_d;
            tmo_q     <= tmo_d;
            bank_q    <= bank_d;
            pkt_len_q <= pkt_len_d;
            new_q     <= new_d;
            err_q     <= err_d;
            busy_q    <= (state_d != S_IDLE);
            // Uses the bank/length in effect at this edge, so a read sampled
            // during the publish pulse already sees the new packet.
            rd_q      <= rd_in_range ? mem[{bank_q, incoming_packet_read_index}] : 8'h00;
        end
    end

    // Payload always lands in the unpublished bank.
    always_ff @(posedge clock) begin
        if (mem_we && reset_n) begin
            mem[{~bank_q, cnt_q}] <= rx_data;
        end
    end

    assign incoming_packet_read_data = rd_q;
    assign incoming_packet_new       = new_q;
    assign incoming_packet_length    = pkt_len_q;
    assign frame_error               = err_q;
    assign busy                      = busy_q;

endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: table vectors, directed corner sequences and random frames against a frame-level model.
// Latency: one tick per clock; outputs compared 1 time unit after each rising edge.
// Backpressure: none; the link is driven freely.
module tb_packet_receiver;

    localparam int TMO = 1024;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [5:0] read_index = 6'd0;
    logic [7:0] incoming_packet_read_data;
    logic       incoming_packet_new;
    logic [6:0] incoming_packet_length;
    logic       frame_error;
    logic       busy;

    packet_receiver #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(1024),
        .TIMEOUT_WIDTH (11)
    ) dut (
        .clock                     (clock),
        .reset_n                   (reset_n),
        .rx_data                   (rx_data),
        .rx_valid                  (rx_valid),
        .incoming_packet_read_index(read_index),
        .incoming_packet_read_data (incoming_packet_read_data),
        .incoming_packet_new       (incoming_packet_new),
        .incoming_packet_length    (incoming_packet_length),
        .frame_error               (frame_error),
        .busy                      (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    bit         in_frame;
    logic [7:0] frm[$];        // LEN, payload..., CHK collected since SYNC
    int         idle_cnt;
    int         pub_len;
    logic [7:0] pub [64];
    logic       m_new, m_err, m_busy;
    logic [7:0] m_rd;

    task automatic model_step(input logic r, input logic v, input logic [7:0] d, input logic [5:0] idx);
        logic [7:0] x;
        m_new = 1'b0;
        m_err = 1'b0;
        if (!r) begin
            in_frame = 1'b0;
            frm.delete();
            idle_cnt = 0;
            pub_len  = 0;
            m_rd     = 8'h00;
            m_busy   = 1'b0;
            return;
        end
        m_rd = (int'(idx) < pub_len) ? pub[idx] : 8'h00;
        if (!in_frame) begin
            if (v && d == 8'hA5) begin
                in_frame = 1'b1;
                frm.delete();
                idle_cnt = 0;
            end
        end else if (v) begin
            idle_cnt = 0;
            frm.push_back(d);
            if (frm.size() == 1) begin
                if (d == 8'd0 || d > 8'd64) begin
                    m_err    = 1'b1;
                    in_frame = 1'b0;
                end
            end else if (frm.size() == int'(frm[0]) + 2) begin
                x = 8'h00;
                for (int k = 0; k < frm.size() - 1; k++) x = x ^ frm[k];
                if (x == d) begin
                    m_new   = 1'b1;
                    pub_len = int'(frm[0]);
                    for (int k = 0; k < pub_len; k++) pub[k] = frm[k+1];
                end else begin
                    m_err = 1'b1;
                end
                in_frame = 1'b0;
            end
        end else begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                m_err    = 1'b1;
                in_frame = 1'b0;
            end
        end
        m_busy = in_frame;
    endtask

    // One clock: drive inputs, step the model at the edge, compare after it.
    task automatic tick(input logic r, input logic v, input logic [7:0] d, input logic [5:0] idx);
        reset_n    = r;
        rx_valid   = v;
        rx_data    = d;
        read_index = idx;
        @(posedge clock);
        model_step(r, v, d, idx);
        #1;
        check("model_new",  incoming_packet_new,       m_new);
        check("model_err",  frame_error,               m_err);
        check("model_busy", busy,                      m_busy);
        check("model_len",  incoming_packet_length,    pub_len);
        check("model_rd",   incoming_packet_read_data, m_rd);
    endtask

    task automatic send(input logic [7:0] b, input logic [5:0] idx);
        tick(1'b1, 1'b1, b, idx);
    endtask

    task automatic idle(input int n, input logic [5:0] idx);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 8'h00, idx);
    endtask

    function automatic logic [5:0] rnd_idx();
        if ($urandom_range(0, 1) == 0) return 6'($urandom_range(0, 7));
        return 6'($urandom_range(0, 63));
    endfunction

    // ---------------- table vectors ----------------
    typedef struct {
        logic       rst_n;
        logic       vld;
        logic [7:0] dat;
        logic [5:0] idx;
        logic       e_new;
        logic       e_err;
        logic       e_busy;
        logic [6:0] e_len;
        logic [7:0] e_rd;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d, input logic [5:0] i,
                                input logic n, input logic e, input logic b, input logic [6:0] l,
                                input logic [7:0] rd);
        vec_t t;
        t.rst_n = r; t.vld = v; t.dat = d; t.idx = i;
        t.e_new = n; t.e_err = e; t.e_busy = b; t.e_len = l; t.e_rd = rd;
        return t;
    endfunction

    initial begin
        vec_t       tbl[21];
        int         kind;
        int         len;
        int         gap;
        logic [7:0] fb[$];
        logic [7:0] x;

        // good frame A5 04 11 22 33 44 40, reads, then the same frame with bad CHK 41
        tbl[0]  = mk(1'b0, 1'b0, 8'h00, 6'd0,  1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
        tbl[1]  = mk(1'b1, 1'b1, 8'hA5, 6'd0,  1'b0, 1'b0, 1'b1, 7'd0, 8'h00);
        tbl[2]  = mk(1'b1, 1'b1, 8'h04, 6'd0,  1'b0, 1'b0, 1'b1, 7'd0, 8'h00);
        tbl[3]  = mk(1'b1, 1'b1, 8'h11, 6'd0,  1'b0, 1'b0, 1'b1, 7'd0, 8'h00);
        tbl[4]  = mk(1'b1, 1'b1, 8'h22, 6'd0,  1'b0, 1'b0, 1'b1, 7'd0, 8'h00);
        tbl[5]  = mk(1'b1, 1'b1, 8'h33, 6'd0,  1'b0, 1'b0, 1'b1, 7'd0, 8'h00);
        tbl[6]  = mk(1'b1, 1'b1, 8'h44, 6'd0,  1'b0, 1'b0, 1'b1, 7'd0, 8'h00);
        tbl[7]  = mk(1'b1, 1'b1, 8'h40, 6'd0,  1'b1, 1'b0, 1'b0, 7'd4, 8'h00);
        tbl[8]  = mk(1'b1, 1'b0, 8'h00, 6'd0,  1'b0, 1'b0, 1'b0, 7'd4, 8'h11);
        tbl[9]  = mk(1'b1, 1'b0, 8'h00, 6'd1,  1'b0, 1'b0, 1'b0, 7'd4, 8'h22);
        tbl[10] = mk(1'b1, 1'b0, 8'h00, 6'd3,  1'b0, 1'b0, 1'b0, 7'd4, 8'h44);
        tbl[11] = mk(1'b1, 1'b0, 8'h00, 6'd4,  1'b0, 1'b0, 1'b0, 7'd4, 8'h00);
        tbl[12] = mk(1'b1, 1'b0, 8'h00, 6'd63, 1'b0, 1'b0, 1'b0, 7'd4, 8'h00);
        tbl[13] = mk(1'b1, 1'b1, 8'hA5, 6'd0,  1'b0, 1'b0, 1'b1, 7'd4, 8'h11);
        tbl[14] = mk(1'b1, 1'b1, 8'h04, 6'd0,  1'b0, 1'b0, 1'b1, 7'd4, 8'h11);
        tbl[15] = mk(1'b1, 1'b1, 8'h11, 6'd0,  1'b0, 1'b0, 1'b1, 7'd4, 8'h11);
        tbl[16] = mk(1'b1, 1'b1, 8'h22, 6'd0,  1'b0, 1'b0, 1'b1, 7'd4, 8'h11);
        tbl[17] = mk(1'b1, 1'b1, 8'h33, 6'd0,  1'b0, 1'b0, 1'b1, 7'd4, 8'h11);
        tbl[18] = mk(1'b1, 1'b1, 8'h44, 6'd0,  1'b0, 1'b0, 1'b1, 7'd4, 8'h11);
        tbl[19] = mk(1'b1, 1'b1, 8'h41, 6'd0,  1'b0, 1'b1, 1'b0, 7'd4, 8'h11);
        tbl[20] = mk(1'b1, 1'b0, 8'h00, 6'd2,  1'b0, 1'b0, 1'b0, 7'd4, 8'h33);

        for (int k = 0; k < 21; k++) begin
            tick(tbl[k].rst_n, tbl[k].vld, tbl[k].dat, tbl[k].idx);
            check($sformatf("tbl%0d_new", k),  incoming_packet_new,       tbl[k].e_new);
            check($sformatf("tbl%0d_err", k),  frame_error,               tbl[k].e_err);
            check($sformatf("tbl%0d_busy", k), busy,                      tbl[k].e_busy);
            check($sformatf("tbl%0d_len", k),  incoming_packet_length,    tbl[k].e_len);
            check($sformatf("tbl%0d_rd", k),   incoming_packet_read_data, tbl[k].e_rd);
        end

        // LEN == 0 and LEN > 64 are rejected right after the LEN byte
        send(8'hA5, 6'd0);
        send(8'h00, 6'd0);
        check("len0_err", frame_error, 1'b1);
        check("len0_busy", busy, 1'b0);
        send(8'hA5, 6'd0);
        send(8'h41, 6'd0);
        check("len65_err", frame_error, 1'b1);
        check("len65_busy", busy, 1'b0);
        send(8'hA5, 6'd0);
        send(8'h01, 6'd0);
        send(8'h5A, 6'd0);
        send(8'h5B, 6'd0);
        check("after_badlen_new", incoming_packet_new, 1'b1);
        check("after_badlen_len", incoming_packet_length, 7'd1);
        idle(1, 6'd0);
        check("after_badlen_rd", incoming_packet_read_data, 8'h5A);

        // timeout: 1024 idle clocks after a byte drops the frame
        send(8'hA5, 6'd0);
        send(8'h02, 6'd0);
        send(8'hAA, 6'd0);
        idle(TMO - 1, 6'd0);
        check("tmo_pre_busy", busy, 1'b1);
        check("tmo_pre_err", frame_error, 1'b0);
        idle(1, 6'd0);
        check("tmo_err", frame_error, 1'b1);
        check("tmo_busy", busy, 1'b0);
        idle(1, 6'd0);
        check("tmo_err_once", frame_error, 1'b0);

        // a byte on the expiry cycle wins
        send(8'hA5, 6'd0);
        send(8'h02, 6'd0);
        send(8'hAA, 6'd0);
        idle(TMO - 1, 6'd0);
        send(8'hBB, 6'd0);
        check("tmo_edge_err", frame_error, 1'b0);
        check("tmo_edge_busy", busy, 1'b1);
        send(8'h13, 6'd0);
        check("tmo_edge_new", incoming_packet_new, 1'b1);
        check("tmo_edge_len", incoming_packet_length, 7'd2);

        // 64-byte frame, then a back-to-back 2-byte frame; hold read index 5
        send(8'hA5, 6'd5);
        send(8'h40, 6'd5);
        for (int k = 0; k < 64; k++) send(8'(k), 6'd5);
        send(8'h40, 6'd5);
        check("max_new", incoming_packet_new, 1'b1);
        check("max_len", incoming_packet_length, 7'd64);
        send(8'hA5, 6'd5);
        check("max_rd5", incoming_packet_read_data, 8'h05);
        send(8'h02, 6'd5);
        send(8'h7E, 6'd5);
        send(8'h81, 6'd5);
        send(8'hFD, 6'd5);
        check("b2b_new", incoming_packet_new, 1'b1);
        check("b2b_len", incoming_packet_length, 7'd2);
        check("b2b_rd5_old", incoming_packet_read_data, 8'h05);
        idle(1, 6'd5);
        check("b2b_rd5_new", incoming_packet_read_data, 8'h00);
        idle(1, 6'd0);
        check("b2b_rd0", incoming_packet_read_data, 8'h7E);
        idle(1, 6'd1);
        check("b2b_rd1", incoming_packet_read_data, 8'h81);
        idle(1, 6'd2);
        check("b2b_rd2", incoming_packet_read_data, 8'h00);
        idle(1, 6'd63);
        check("b2b_rd63", incoming_packet_read_data, 8'h00);

        // reset in the middle of a payload, with a byte on the reset cycle
        send(8'hA5, 6'd0);
        send(8'h05, 6'd0);
        send(8'h01, 6'd0);
        send(8'h02, 6'd0);
        tick(1'b0, 1'b1, 8'h03, 6'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", frame_error, 1'b0);
        check("rst_len", incoming_packet_length, 7'd0);
        check("rst_rd", incoming_packet_read_data, 8'h00);
        idle(1, 6'd0);
        check("rst_after_err", frame_error, 1'b0);
        check("rst_after_rd", incoming_packet_read_data, 8'h00);
        send(8'hA5, 6'd0);
        send(8'h01, 6'd0);
        send(8'h5A, 6'd0);
        send(8'h5B, 6'd0);
        check("rst_next_new", incoming_packet_new, 1'b1);
        idle(1, 6'd0);
        check("rst_next_rd", incoming_packet_read_data, 8'h5A);

        // random frames of every kind, checked by the model each cycle
        for (int f = 0; f < 70; f++) begin
            kind = $urandom_range(0, 9);
            fb.delete();
            gap = 0;
            if (kind == 7) begin
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) fb.push_back(8'($urandom_range(0, 255)));
            end else if (kind == 6) begin
                fb.push_back(8'hA5);
                fb.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(65, 255)));
            end else begin
                len = $urandom_range(1, 64);
                fb.push_back(8'hA5);
                fb.push_back(8'(len));
                x = 8'(len);
                for (int k = 0; k < len; k++) begin
                    fb.push_back(8'($urandom_range(0, 255)));
                    x = x ^ fb[fb.size() - 1];
                end
                if (kind == 8) begin
                    fb = fb[0:$urandom_range(1, fb.size() - 1)];
                end else begin
                    fb.push_back((kind == 5) ? (x ^ 8'($urandom_range(1, 255))) : x);
                end
                if (kind == 9) gap = $urandom_range(TMO - 4, TMO + 2);
            end
            for (int k = 0; k < fb.size(); k++) begin
                while ($urandom_range(0, 3) == 0) idle(1, rnd_idx());
                send(fb[k], rnd_idx());
                if (k == 1 && gap > 0) idle(gap, rnd_idx());
            end
        end
        idle(TMO + 2, rnd_idx());
        check("final_idle_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
